// File: rtl/axi_wr_frontend_pkg.sv
// ---------------------------------------------------------------------------
// axi_wr_frontend_pkg
// Shared definitions for the AXI write-channel front end of the DDR2
// controller: the FSM state encoding, the B-channel response codes, and a
// helper that decides whether a burst fits in the local write buffer.
// ---------------------------------------------------------------------------
package axi_wr_frontend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_CMD     = 3'd3,
        ST_WAIT    = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A burst of len+1 beats is legal only if the whole burst can be held in
    // the buffer, because the burst is forwarded store-and-forward.
    function automatic logic burst_fits(input logic [7:0] len, input int unsigned depth);
        return ({24'd0, len} + 32'd1) <= depth;
    endfunction

endpackage

// File: rtl/axi_wr_frontend_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding one write burst between the AXI W channel and
// the DDR2 command scheduler.
//
// Ports:
//   clk, rstn    controller clock, asynchronous active-low reset
//   push, din    write one word (ignored when full or flushing)
//   pop          advance the read pointer (ignored when empty or flushing)
//   flush        return to empty in one cycle; wins over push and pop
//   full, empty  status flags
//   dout         head word; combinational from storage when FWFT=1,
//                otherwise registered on pop
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter bit FWFT       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    // The extra pointer MSB separates "full" from "empty" when the low
    // address bits coincide.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic do_push;
    logic do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define which words are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

    generate
        if (FWFT) begin : g_fwft
            assign dout = mem[rd_ptr_q[AW-1:0]];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q, dout_d;
            always_comb begin
                dout_d = dout_q;
                if (do_pop) dout_d = mem[rd_ptr_q[AW-1:0]];
            end
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) dout_q <= '0;
                else       dout_q <= dout_d;
            end
            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: rtl/axi_wr_frontend.sv
// ---------------------------------------------------------------------------
// axi_wr_frontend
// AXI write-channel slave front end of the DDR2 controller. One burst at a
// time is accepted, buffered completely, issued to the command scheduler as
// a single write command, streamed out on demand, and acknowledged on B once
// the scheduler reports completion.
//
// Ports:
//   clk, rstn                 controller clock, async active-low reset
//   init_end                  DDR init done; gates AW acceptance
//   aw*  (valid/ready/addr/len) AXI write address channel
//   w*   (valid/ready/last/data) AXI write data channel
//   b*   (valid/ready/resp)   AXI write response channel
//   cmd_valid/ready/addr/len  write command to the scheduler
//   wr_data_en, wr_data       scheduler pops buffered beats (FWFT head)
//   cmd_done                  scheduler finished the burst (1-cycle pulse)
// ---------------------------------------------------------------------------
module axi_wr_frontend
    import axi_wr_frontend_pkg::*;
#(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  init_end,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  wlast,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_len,
    input  logic                  wr_data_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  cmd_done
);

    state_e                state_q, state_d;
    logic                  err_q, err_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]            cmd_len_q, cmd_len_d;
    logic                  awready_q, awready_d;

    logic fifo_push;
    logic fifo_pop;
    logic fifo_flush;
    logic fifo_full;
    logic fifo_empty;

    logic aw_hs;
    logic w_hs;

    // Channel readies/valids come from registered state only, never from the
    // matching valid input.
    assign awready   = awready_q;
    assign wready    = ((state_q == ST_COLLECT) && !fifo_full) || (state_q == ST_DRAIN);
    assign cmd_valid = (state_q == ST_CMD);
    assign bvalid    = (state_q == ST_RESP);
    assign bresp     = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;

    assign aw_hs = awvalid && awready_q;
    assign w_hs  = wvalid && wready;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FWFT       (1'b1)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .din   (wdata),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (wr_data)
    );

    // Next-state logic. Any protocol error marks the burst for SLVERR and
    // drops whatever is buffered so the scheduler never sees partial data.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        beat_cnt_d = beat_cnt_q;
        cmd_addr_d = cmd_addr_q;
        cmd_len_d  = cmd_len_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    cmd_addr_d = awaddr;
                    cmd_len_d  = awlen;
                    if (burst_fits(awlen, FIFO_DEPTH)) begin
                        state_d = ST_COLLECT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_COLLECT: begin
                if (w_hs) begin
                    fifo_push  = 1'b1;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == cmd_len_q) begin
                        if (wlast) begin
                            state_d = ST_CMD;
                        end else begin
                            err_d      = 1'b1;
                            fifo_flush = 1'b1;
                            state_d    = ST_RESP;
                        end
                    end else if (wlast) begin
                        err_d      = 1'b1;
                        fifo_flush = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_hs && wlast) state_d = ST_RESP;
            end
            ST_CMD: begin
                if (cmd_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Pops on an empty FIFO are swallowed inside the FIFO.
                fifo_pop = wr_data_en;
                if (cmd_done) begin
                    if (!fifo_empty) begin
                        err_d      = 1'b1;
                        fifo_flush = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bready) begin
                    err_d      = 1'b0;
                    beat_cnt_d = 8'd0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered so awready can only rise the cycle after returning to IDLE.
        awready_d = (state_d == ST_IDLE) && init_end;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            beat_cnt_q <= 8'd0;
            cmd_addr_q <= '0;
            cmd_len_q  <= 8'd0;
            awready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            beat_cnt_q <= beat_cnt_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_len_q  <= cmd_len_d;
            awready_q  <= awready_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_frontend.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_frontend
// Drives directed and random write bursts into axi_wr_frontend. Each burst's
// expected command, data stream and response are derived from the burst's
// length and wlast position and queued; a monitor process compares them as
// the design presents them.
// ---------------------------------------------------------------------------
module tb_axi_wr_frontend;

    localparam int AW    = 27;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int BUDGET = 300;

    logic          clk = 1'b0;
    logic          rstn;
    logic          init_end;
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic          wvalid;
    logic          wready;
    logic          wlast;
    logic [DW-1:0] wdata;
    logic          bvalid;
    logic          bready;
    logic [1:0]    bresp;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          wr_data_en;
    logic [DW-1:0] wr_data;
    logic          cmd_done;

    logic          expect_pop;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] exp_cmd_addr_q[$];
    logic [7:0]    exp_cmd_len_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [1:0]    exp_resp_q[$];

    always #5 clk = ~clk;

    axi_wr_frontend #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .init_end   (init_end),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .awlen      (awlen),
        .wvalid     (wvalid),
        .wready     (wready),
        .wlast      (wlast),
        .wdata      (wdata),
        .bvalid     (bvalid),
        .bready     (bready),
        .bresp      (bresp),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_data_en (wr_data_en),
        .wr_data    (wr_data),
        .cmd_done   (cmd_done)
    );

    // One comparison: count it, and report it if it does not match.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    function automatic logic sigOf(input int which);
        case (which)
            0:       return awready;
            1:       return wready;
            2:       return cmd_valid;
            3:       return bvalid;
            default: return 1'b0;
        endcase
    endfunction

    // Waits (bounded) until the selected DUT output is high at a falling edge.
    task automatic waitHigh(input int which, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!sigOf(which) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!sigOf(which)) checkOutput(name, 32'(sigOf(which)), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_awready"},   32'(awready),   32'd0);
        checkOutput({tag, "_wready"},    32'(wready),    32'd0);
        checkOutput({tag, "_bvalid"},    32'(bvalid),    32'd0);
        checkOutput({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        checkOutput({tag, "_bresp"},     32'(bresp),     32'd0);
        checkOutput({tag, "_cmd_addr"},  32'(cmd_addr),  32'd0);
        checkOutput({tag, "_cmd_len"},   32'(cmd_len),   32'd0);
    endtask

    // Monitor: every output transfer is matched against the head of its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1) begin
                if (cmd_valid) begin
                    if (exp_cmd_addr_q.size() == 0) begin
                        checkOutput("unexpected_cmd_valid", 32'(cmd_valid), 32'd0);
                    end else if (cmd_ready) begin
                        checkOutput("cmd_addr", 32'(cmd_addr), 32'(exp_cmd_addr_q.pop_front()));
                        checkOutput("cmd_len",  32'(cmd_len),  32'(exp_cmd_len_q.pop_front()));
                    end
                end
                if (wr_data_en && expect_pop) begin
                    if (exp_data_q.size() == 0)
                        checkOutput("data_queue_level", 32'(exp_data_q.size()), 32'd1);
                    else
                        checkOutput("wr_data", 32'(wr_data), 32'(exp_data_q.pop_front()));
                end
                if (bvalid && bready) begin
                    if (exp_resp_q.size() == 0)
                        checkOutput("unexpected_bvalid", 32'(bvalid), 32'd0);
                    else
                        checkOutput("bresp", 32'(bresp), 32'(exp_resp_q.pop_front()));
                end
            end
        end
    end

    // One complete burst. The outcome (accepted beats, command or not,
    // response code) follows from len and the position of wlast alone.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [7:0] len,
                                 input int wlast_pos, input int cmd_stall, input int b_stall,
                                 input bit seq_data, input bit empty_pop, input bit reset_in_wait);
        bit            fits;
        bit            ok;
        int            beats;
        int            npop;
        logic [1:0]    exp_resp;
        logic [DW-1:0] data[$];

        fits = (int'(len) + 1) <= DEPTH;
        if (!fits) begin
            beats = wlast_pos + 1;
            ok    = 1'b0;
        end else begin
            beats = ((wlast_pos < int'(len)) ? wlast_pos : int'(len)) + 1;
            ok    = (wlast_pos == int'(len));
        end
        for (int i = 0; i < beats; i++) data.push_back(seq_data ? DW'(i) : DW'($urandom));
        exp_resp = ok ? 2'b00 : 2'b10;

        if (ok) begin
            exp_cmd_addr_q.push_back(addr);
            exp_cmd_len_q.push_back(len);
            foreach (data[i]) exp_data_q.push_back(data[i]);
        end
        exp_resp_q.push_back(exp_resp);
        cmd_ready = (ok && cmd_stall > 0) ? 1'b0 : 1'b1;

        // address phase
        @(posedge clk); #1;
        awvalid = 1'b1;
        awaddr  = addr;
        awlen   = len;
        waitHigh(0, "awready_timeout");
        @(posedge clk); #1;
        awvalid = 1'b0;
        awaddr  = '0;
        awlen   = 8'd0;

        // data phase with occasional idle cycles
        for (int i = 0; i < beats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            wvalid = 1'b1;
            wdata  = data[i];
            wlast  = (i == wlast_pos);
            waitHigh(1, "wready_timeout");
            @(posedge clk); #1;
            wvalid = 1'b0;
            wlast  = 1'b0;
        end

        if (ok) begin
            waitHigh(2, "cmd_valid_timeout");
            if (cmd_stall > 0) begin
                for (int s = 0; s < cmd_stall; s++) begin
                    if (s > 0) @(negedge clk);
                    checkOutput("stall_cmd_valid", 32'(cmd_valid), 32'd1);
                    checkOutput("stall_cmd_addr",  32'(cmd_addr),  32'(addr));
                    checkOutput("stall_cmd_len",   32'(cmd_len),   32'(len));
                    checkOutput("stall_awready",   32'(awready),   32'd0);
                    @(posedge clk); #1;
                end
                cmd_ready = 1'b1;
                @(negedge clk);
            end
            @(posedge clk); #1;

            npop = reset_in_wait ? 3 : beats;
            for (int i = 0; i < npop; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                wr_data_en = 1'b1;
                expect_pop = 1'b1;
                @(posedge clk); #1;
                wr_data_en = 1'b0;
                expect_pop = 1'b0;
            end

            if (reset_in_wait) begin
                // The interrupted burst never produces data or a response.
                exp_data_q.delete();
                exp_resp_q.delete();
                exp_cmd_addr_q.delete();
                exp_cmd_len_q.delete();
                rstn = 1'b0;
                #1;
                checkResetOutputs("midreset");
                @(posedge clk); #1;
                rstn = 1'b1;
                return;
            end

            if (empty_pop) begin
                wr_data_en = 1'b1;
                @(posedge clk); #1;
                wr_data_en = 1'b0;
            end
            cmd_done = 1'b1;
            @(posedge clk); #1;
            cmd_done = 1'b0;
        end

        // response phase
        waitHigh(3, "bvalid_timeout");
        for (int s = 0; s < b_stall; s++) begin
            if (s > 0) @(negedge clk);
            checkOutput("stall_bvalid",  32'(bvalid),  32'd1);
            checkOutput("stall_bresp",   32'(bresp),   32'(exp_resp));
            checkOutput("stall_awready", 32'(awready), 32'd0);
            @(posedge clk); #1;
        end
        if (b_stall == 0) begin
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(negedge clk);
        checkOutput("awready_during_b", 32'(awready), 32'd0);
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        checkOutput("awready_after_b", 32'(awready), 32'd1);
        checkOutput("bvalid_after_b",  32'(bvalid),  32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn       = 1'b0;
        init_end   = 1'b0;
        awvalid    = 1'b0;
        awaddr     = '0;
        awlen      = 8'd0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        wdata      = '0;
        bready     = 1'b0;
        cmd_ready  = 1'b1;
        wr_data_en = 1'b0;
        cmd_done   = 1'b0;
        expect_pop = 1'b0;

        #1;
        checkResetOutputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // AW offered before DDR init completes must not be taken.
        awvalid = 1'b1;
        awaddr  = AW'(32'h40);
        awlen   = 8'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("awready_gated", 32'(awready), 32'd0);
        end
        @(posedge clk); #1;
        awvalid  = 1'b0;
        init_end = 1'b1;

        $display("[TB] nominal burst");
        applyStimulus(AW'(32'h10), 8'd7, 7, 0, 0, 1'b1, 1'b0, 1'b0);
        $display("[TB] oversized burst");
        applyStimulus(AW'(32'h100), 8'd20, 20, 0, 0, 1'b0, 1'b0, 1'b0);
        $display("[TB] early wlast then short burst");
        applyStimulus(AW'(32'h200), 8'd7, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(AW'(32'h300), 8'd3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        $display("[TB] missing wlast");
        applyStimulus(AW'(32'h340), 8'd3, 6, 0, 0, 1'b0, 1'b0, 1'b0);
        $display("[TB] backpressure");
        applyStimulus(AW'(32'h400), 8'd5, 5, 10, 5, 1'b0, 1'b0, 1'b0);
        $display("[TB] pop on empty FIFO");
        applyStimulus(AW'(32'h500), 8'd2, 2, 0, 0, 1'b0, 1'b1, 1'b0);
        $display("[TB] reset during WAIT, then full-depth burst");
        applyStimulus(AW'(32'h600), 8'd7, 7, 0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(AW'(32'h700), 8'd15, 15, 0, 0, 1'b0, 1'b0, 1'b0);
        $display("[TB] back-to-back");
        applyStimulus(AW'(32'h10), 8'd3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(AW'(32'h20), 8'd3, 3, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] random bursts");
        for (int k = 0; k < 20; k++) begin
            logic [7:0] rlen;
            int         rpos;
            rlen = 8'($urandom_range(0, 20));
            rpos = ($urandom_range(0, 9) < 7) ? int'(rlen) : int'($urandom_range(0, 20));
            applyStimulus(AW'($urandom), rlen, rpos, int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 4)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        checkOutput("queues_drained",
                    32'(exp_cmd_addr_q.size() + exp_data_q.size() + exp_resp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
